// File: rtl/gift_pkg.sv
// GIFT cipher primitives shared by the round datapath and the iterative core:
// S-box, bit-permutation index, round counts, round-constant LFSR and FSM encoding.
package gift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Nibble n counted from the MSB end holds S(n).
  localparam logic [63:0] SBOX_TAB = 64'h1A4C6F392DB7508E;

  function automatic logic [3:0] sbox_f(input logic [3:0] x);
    logic [63:0] tab;
    tab    = SBOX_TAB;
    sbox_f = tab[60 - 4*int'(x) +: 4];
  endfunction

  // Destination bit of source bit i in the GIFT bit permutation of a width-bit block.
  function automatic int perm_idx_f(input int width, input int i);
    perm_idx_f = 4*(i/16) + (width/4)*((3*((i%16)/4) + i%4) % 4) + i%4;
  endfunction

  function automatic int rounds_f(input int width);
    rounds_f = (width == 64) ? 28 : 40;
  endfunction

  function automatic logic [5:0] lfsr_next_f(input logic [5:0] c);
    lfsr_next_f = {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/gift_round.sv
// One combinational GIFT round: SubCells, PermBits, AddRoundKey, AddRoundConstant,
// plus the key-schedule and round-constant updates feeding the next round.
module gift_round
  import gift_pkg::*;
#(
  parameter int BLOCK_W = 128
) (
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [127:0]       key_i,
  input  logic [5:0]         lfsr_i,
  output logic [BLOCK_W-1:0] state_o,
  output logic [127:0]       key_o,
  output logic [5:0]         lfsr_o
);

  logic [BLOCK_W-1:0] sub_s;
  logic [BLOCK_W-1:0] perm_s;
  logic [BLOCK_W-1:0] mix_s;

  for (genvar n = 0; n < BLOCK_W/4; n++) begin : g_sbox
    assign sub_s[4*n +: 4] = sbox_f(state_i[4*n +: 4]);
  end

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_perm
    assign perm_s[perm_idx_f(BLOCK_W, i)] = sub_s[i];
  end

  // The constant for this round is the freshly stepped LFSR value.
  assign lfsr_o = lfsr_next_f(lfsr_i);

  always_comb begin
    mix_s = perm_s;
    for (int i = 0; i < BLOCK_W/4; i++) begin
      if (BLOCK_W == 64) begin
        mix_s[4*i+1] = mix_s[4*i+1] ^ key_i[16+i];
        mix_s[4*i]   = mix_s[4*i]   ^ key_i[i];
      end else begin
        mix_s[4*i+2] = mix_s[4*i+2] ^ key_i[64+i];
        mix_s[4*i+1] = mix_s[4*i+1] ^ key_i[i];
      end
    end
    for (int j = 0; j < 6; j++) begin
      mix_s[4*j+3] = mix_s[4*j+3] ^ lfsr_o[j];
    end
    mix_s[BLOCK_W-1] = ~mix_s[BLOCK_W-1];
  end

  assign state_o = mix_s;

  // k7..k0 <- (k1 >>> 2) | (k0 >>> 12) | k7..k2
  assign key_o = {key_i[17:16], key_i[31:18], key_i[11:0], key_i[15:12], key_i[127:32]};

endmodule

// File: rtl/gift_iter_core.sv
// Iterative GIFT-64/128 encryptor applying UNROLL rounds per clock behind valid/ready handshakes.
// Defining GIFT_ROUND_TRACE_EN adds per-step trace ports (trace_valid, trace_state, trace_round).
module gift_iter_core
  import gift_pkg::*;
#(
  parameter int BLOCK_W = 128,
  parameter int UNROLL  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plain,
  input  logic [127:0]       key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] cipher,
  output logic               busy
`ifdef GIFT_ROUND_TRACE_EN
  ,
  output logic               trace_valid,
  output logic [BLOCK_W-1:0] trace_state,
  output logic [5:0]         trace_round
`endif
);

  localparam int ROUNDS = rounds_f(BLOCK_W);
  localparam int STEPS  = ROUNDS / UNROLL;
  localparam int CNT_W  = $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (BLOCK_W != 64 && BLOCK_W != 128) begin : g_bad_block_w
    $error("gift_iter_core: BLOCK_W must be 64 or 128");
  end
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("gift_iter_core: UNROLL must be 1, 2 or 4");
  end

  fsm_t               fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [5:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] cipher_q, cipher_d;

  logic [BLOCK_W-1:0] chain_state [UNROLL+1];
  logic [127:0]       chain_key   [UNROLL+1];
  logic [5:0]         chain_lfsr  [UNROLL+1];

  assign chain_state[0] = state_q;
  assign chain_key[0]   = key_q;
  assign chain_lfsr[0]  = lfsr_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    gift_round #(.BLOCK_W(BLOCK_W)) u_round (
      .state_i (chain_state[u]),
      .key_i   (chain_key[u]),
      .lfsr_i  (chain_lfsr[u]),
      .state_o (chain_state[u+1]),
      .key_o   (chain_key[u+1]),
      .lfsr_o  (chain_lfsr[u+1])
    );
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    key_d    = key_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    cipher_d = cipher_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = plain;
          key_d   = key;
          lfsr_d  = '0;
          cnt_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = chain_state[UNROLL];
        key_d   = chain_key[UNROLL];
        lfsr_d  = chain_lfsr[UNROLL];
        // Hold the counter on the final step so it never wraps within a job.
        if (cnt_q == CNT_LAST) begin
          cipher_d = chain_state[UNROLL];
          fsm_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      lfsr_q   <= 6'h00;
      cnt_q    <= '0;
      cipher_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      key_q    <= key_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      cipher_q <= cipher_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN);
  assign cipher    = cipher_q;

`ifdef GIFT_ROUND_TRACE_EN
  logic               trace_valid_q, trace_valid_d;
  logic [BLOCK_W-1:0] trace_state_q, trace_state_d;
  logic [5:0]         trace_round_q, trace_round_d;

  always_comb begin
    trace_valid_d = (fsm_q == RUN);
    trace_state_d = trace_state_q;
    trace_round_d = trace_round_q;
    if (fsm_q == RUN) begin
      trace_state_d = chain_state[UNROLL];
      trace_round_d = 6'((int'(cnt_q) + 1) * UNROLL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_valid_q <= 1'b0;
      trace_state_q <= '0;
      trace_round_q <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_state_q <= trace_state_d;
      trace_round_q <= trace_round_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_state = trace_state_q;
  assign trace_round = trace_round_q;
`endif

endmodule

// File: tb/tb_gift_iter_core.sv
// Bench for gift_iter_core: GIFT-128/UNROLL=1 instance plus a GIFT-64 pair (UNROLL=4 and 1)
// sharing inputs, all checked against a round-by-round reference model.
module tb_gift_iter_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [127:0] a_plain = '0, a_key = '0;
  logic         a_in_ready, a_out_valid, a_busy;
  logic [127:0] a_cipher;

  logic         b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [63:0]  b_plain = '0;
  logic [127:0] b_key = '0;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [63:0]  b_cipher;
  logic         c_in_ready, c_out_valid, c_busy;
  logic [63:0]  c_cipher;

`ifdef GIFT_ROUND_TRACE_EN
  logic a_tv, b_tv, c_tv;
  logic [127:0] a_ts;
  logic [63:0] b_ts, c_ts;
  logic [5:0] a_tr, b_tr, c_tr;
`endif

  gift_iter_core #(.BLOCK_W(128), .UNROLL(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .plain(a_plain),
    .key(a_key), .out_valid(a_out_valid), .out_ready(a_out_ready), .cipher(a_cipher), .busy(a_busy)
`ifdef GIFT_ROUND_TRACE_EN
    , .trace_valid(a_tv), .trace_state(a_ts), .trace_round(a_tr)
`endif
  );

  gift_iter_core #(.BLOCK_W(64), .UNROLL(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .plain(b_plain),
    .key(b_key), .out_valid(b_out_valid), .out_ready(b_out_ready), .cipher(b_cipher), .busy(b_busy)
`ifdef GIFT_ROUND_TRACE_EN
    , .trace_valid(b_tv), .trace_state(b_ts), .trace_round(b_tr)
`endif
  );

  gift_iter_core #(.BLOCK_W(64), .UNROLL(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(c_in_ready), .plain(b_plain),
    .key(b_key), .out_valid(c_out_valid), .out_ready(b_out_ready), .cipher(c_cipher), .busy(c_busy)
`ifdef GIFT_ROUND_TRACE_EN
    , .trace_valid(c_tv), .trace_state(c_ts), .trace_round(c_tr)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference GIFT encryption: whole cipher unrolled in plain loops over bits and key words.
  function automatic logic [127:0] ref_enc(input int w, input logic [127:0] p, input logic [127:0] k);
    logic [3:0]   sb [16];
    logic [15:0]  kw [8];
    logic [15:0]  nk [8];
    logic [127:0] s, t;
    logic [31:0]  u, v;
    logic [5:0]   c;
    int nr, dst;
    sb = '{4'h1, 4'hA, 4'h4, 4'hC, 4'h6, 4'hF, 4'h3, 4'h9,
           4'h2, 4'hD, 4'hB, 4'h7, 4'h5, 4'h0, 4'h8, 4'hE};
    nr = (w == 64) ? 28 : 40;
    for (int j = 0; j < 8; j++) kw[j] = k[16*j +: 16];
    s = p;
    c = 6'd0;
    for (int r = 0; r < nr; r++) begin
      t = '0;
      for (int n = 0; n < w/4; n++) t[4*n +: 4] = sb[s[4*n +: 4]];
      s = '0;
      for (int i = 0; i < w; i++) begin
        dst = 4*(i/16) + (w/4)*((3*((i%16)/4) + i%4) % 4) + i%4;
        s[dst] = t[i];
      end
      if (w == 64) begin
        u = {16'h0, kw[1]};
        v = {16'h0, kw[0]};
      end else begin
        u = {kw[5], kw[4]};
        v = {kw[1], kw[0]};
      end
      for (int i = 0; i < w/4; i++) begin
        if (w == 64) begin
          s[4*i+1] ^= u[i];
          s[4*i]   ^= v[i];
        end else begin
          s[4*i+2] ^= u[i];
          s[4*i+1] ^= v[i];
        end
      end
      c = {c[4:0], ~(c[5] ^ c[4])};
      s[w-1] ^= 1'b1;
      s[23] ^= c[5]; s[19] ^= c[4]; s[15] ^= c[3];
      s[11] ^= c[2]; s[7]  ^= c[1]; s[3]  ^= c[0];
      nk[7] = (kw[1] >> 2) | (kw[1] << 14);
      nk[6] = (kw[0] >> 12) | (kw[0] << 4);
      for (int j = 0; j < 6; j++) nk[j] = kw[j+2];
      kw = nk;
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic a_accept(input logic [127:0] p, input logic [127:0] k);
    int n = 0;
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    a_plain = p;
    a_key = k;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  // lat = clock edges after the accept edge until out_valid is seen.
  task automatic a_wait(output logic [127:0] ct, output int lat);
    lat = 0;
    while (!a_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    ct = a_cipher;
  endtask

  task automatic b_job(input logic [63:0] p, input logic [127:0] k,
                       output logic [63:0] ctb, output int latb,
                       output logic [63:0] ctc, output int latc);
    int n = 0;
    bit gb = 1'b0, gc = 1'b0;
    while (!(b_in_ready && c_in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    b_plain = p;
    b_key = k;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    latb = -1; latc = -1; ctb = '0; ctc = '0;
    for (int t = 0; t <= 60 && !(gb && gc); t++) begin
      if (!gb && b_out_valid) begin gb = 1'b1; latb = t; ctb = b_cipher; end
      if (!gc && c_out_valid) begin gc = 1'b1; latc = t; ctc = c_cipher; end
      if (!(gb && gc)) @(negedge clk);
    end
  endtask

  typedef struct {
    int           w;
    logic [127:0] p;
    logic [127:0] k;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  initial begin
    vec_t         tbl [2];
    logic [127:0] ct, p, k, p2, k2, exp, exp2;
    logic [63:0]  ctb, ctc;
    int           lat, latb, latc, sent, got, low;
    bit           seen;
    logic [127:0] expq [$];

    tbl[0] = '{128, 128'h0, 128'h0, 128'hcd0bd738388ad3f668b15a36ceb6ff92, 40};
    tbl[1] = '{64,  128'h0, 128'h0, 128'h0000000000000000f62bc3ef34f775ac, 7};

    // Reset state while rst is held from time zero.
    #3;
    check_i("reset in_ready", int'(a_in_ready), 1);
    check_i("reset out_valid", int'(a_out_valid), 0);
    check_i("reset busy", int'(a_busy), 0);
    check("reset cipher", a_cipher, 128'h0);
    check_i("reset b in_ready", int'(b_in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer table.
    foreach (tbl[i]) begin
      if (tbl[i].w == 128) begin
        a_accept(tbl[i].p, tbl[i].k);
        a_wait(ct, lat);
        check("kat128 cipher", ct, tbl[i].exp);
        check_i("kat128 latency", lat, tbl[i].lat);
      end else begin
        b_job(tbl[i].p[63:0], tbl[i].k, ctb, latb, ctc, latc);
        check("kat64 u4 cipher", {64'h0, ctb}, tbl[i].exp);
        check_i("kat64 u4 latency", latb, tbl[i].lat);
        check("kat64 u1 cipher", {64'h0, ctc}, tbl[i].exp);
        check_i("kat64 u1 latency", latc, 28);
      end
    end

    // Random GIFT-64 jobs on both unroll factors.
    for (int j = 0; j < 8; j++) begin
      p = rand128();
      k = rand128();
      exp = ref_enc(64, {64'h0, p[63:0]}, k);
      b_job(p[63:0], k, ctb, latb, ctc, latc);
      check("rand64 u4 cipher", {64'h0, ctb}, exp);
      check("rand64 u1 cipher", {64'h0, ctc}, exp);
    end

    // Backpressure, with a competing request held through DONE and the DONE->IDLE edge.
    p = rand128(); k = rand128(); exp = ref_enc(128, p, k);
    p2 = rand128(); k2 = rand128(); exp2 = ref_enc(128, p2, k2);
    a_out_ready = 1'b0;
    a_accept(p, k);
    a_wait(ct, lat);
    check("bp cipher", ct, exp);
    a_plain = p2;
    a_key = k2;
    a_in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check_i("bp out_valid held", int'(a_out_valid), 1);
      check("bp cipher stable", a_cipher, exp);
      check_i("bp in_ready low", int'(a_in_ready), 0);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    check_i("release in_ready", int'(a_in_ready), 1);
    check_i("release out_valid", int'(a_out_valid), 0);
    check_i("release busy", int'(a_busy), 0);
    @(negedge clk);
    a_in_valid = 1'b0;
    check_i("late accept busy", int'(a_busy), 1);
    a_wait(ct, lat);
    check("late accept cipher", ct, exp2);
    check_i("late accept latency", lat, 40);

    // Abort during round 17, then a fresh job.
    p = rand128(); k = rand128();
    a_accept(p, k);
    repeat (16) @(negedge clk);
    check_i("pre-abort busy", int'(a_busy), 1);
    #2 rst = 1'b1;
    #1;
    check_i("abort busy", int'(a_busy), 0);
    check_i("abort in_ready", int'(a_in_ready), 1);
    check_i("abort out_valid", int'(a_out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check_i("abort stray out_valid", int'(seen), 0);
    p2 = rand128(); k2 = rand128();
    a_accept(p2, k2);
    a_wait(ct, lat);
    check("post-abort cipher", ct, ref_enc(128, p2, k2));
    check_i("post-abort latency", lat, 40);
    @(negedge clk);

    // Back-to-back: in_valid held high, out_ready high.
    sent = 0; got = 0; low = 0;
    a_in_valid = 1'b1;
    for (int cyc = 0; cyc < 100*45 + 200 && got < 100; cyc++) begin
      if (a_out_valid) begin
        if (expq.size() == 0) begin
          check("b2b unexpected cipher", a_cipher, 128'hx);
        end else begin
          check("b2b cipher", a_cipher, expq.pop_front());
        end
        if (got > 0) check_i("b2b spacing", low, 41);
        got++;
        low = 0;
      end else begin
        low++;
      end
      if (a_in_ready) begin
        if (sent < 100) begin
          p = rand128(); k = rand128();
          a_plain = p;
          a_key = k;
          expq.push_back(ref_enc(128, p, k));
          sent++;
        end else begin
          a_in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    check_i("b2b count", got, 100);

    // Asynchronous reset mid-cycle while a result is being held.
    repeat (2) @(negedge clk);
    a_out_ready = 1'b0;
    p = rand128(); k = rand128();
    a_accept(p, k);
    a_wait(ct, lat);
    check("hold before reset", ct, ref_enc(128, p, k));
    #2 rst = 1'b1;
    #1;
    check_i("async rst in_ready", int'(a_in_ready), 1);
    check_i("async rst out_valid", int'(a_out_valid), 0);
    check("async rst cipher", a_cipher, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
